display_char_scheduler: RTL and testbench

Sequences all character traffic into the terminal display block. It arbitrates between two requesters, the CPU TX port (PIA DSP write) and a host text injector (OSD/ioctl "type-in"), through a small FIFO. It replays each queued character through the display's frame-paced ready/w_en handshake. It also runs full-frame clear-screen sequences so that requesters never interact with the display directly.

---
 rtl/display_char_scheduler.sv | 171 +++++++++++++++++
 tb/tb_display_char_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_char_scheduler.sv
// Character scheduler for the terminal display: two requesters share a small FIFO,
// entries are replayed through the display's frame-paced ready/w_en handshake, and full-frame clears are sequenced.
module display_char_scheduler #(
    parameter int DEPTH     = 16,
    parameter int CLR_TICKS = 119928
) (
    input  logic                   sys_clock,
    input  logic                   reset,
    input  logic                   pixel_clken,
    input  logic                   cpu_clken,
    input  logic                   a_valid,
    input  logic [6:0]             a_data,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic [6:0]             b_data,
    output logic                   b_ready,
    input  logic                   clr_req,
    input  logic                   disp_ready,
    output logic                   disp_w_en,
    output logic                   disp_address,
    output logic [7:0]             disp_din,
    output logic                   disp_clr_screen,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CLR_TICKS > 1) ? $clog2(CLR_TICKS) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_TICKS - 1);
    localparam logic [CW-1:0] CLR_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SETTLE  = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          rr_last_b;
    logic          clr_pend, clr_pend_nxt;
    logic [CW-1:0] clr_cnt, clr_cnt_nxt;
    logic          full, empty;
    logic          push_a, push_b, push, pop;
    logic [6:0]    push_data, head;
    logic          accept, clr_eff;
    logic          w_en_nxt, load_head;

    // Push side: round-robin between the CPU and the host injector
    always_comb begin
        full      = (fifo_count == FULL_CNT);
        empty     = (fifo_count == '0);
        a_ready   = ~full & (~b_valid | rr_last_b);
        b_ready   = ~full & (~a_valid | ~rr_last_b);
        push_a    = a_valid & a_ready;
        push_b    = b_valid & b_ready & ~push_a;
        push      = push_a | push_b;
        push_data = push_a ? a_data : b_data;
    end

    assign head         = mem[rd_ptr];
    assign disp_address = 1'b0;
    assign busy         = full | (state == CLEAR);
    assign accept       = disp_w_en & disp_ready & pixel_clken & cpu_clken;
    assign clr_eff      = clr_req | clr_pend;

    // Output sequencer: next state, strobe and clear-counter updates
    always_comb begin
        state_nxt   = state;
        w_en_nxt    = disp_w_en;
        clr_cnt_nxt = '0;
        load_head   = 1'b0;
        pop         = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_eff) begin
                    state_nxt = CLEAR;
                end else if (!empty) begin
                    state_nxt = PRESENT;
                    w_en_nxt  = 1'b1;
                    load_head = 1'b1;
                end
            end
            PRESENT: begin
                if (accept) begin
                    pop       = 1'b1;
                    w_en_nxt  = 1'b0;
                    state_nxt = clr_eff ? CLEAR : SETTLE;
                end else if (clr_eff) begin
                    w_en_nxt  = 1'b0;
                    state_nxt = CLEAR;
                end
            end
            SETTLE: begin
                if (clr_eff) begin
                    state_nxt = CLEAR;
                end else if (!empty) begin
                    state_nxt = PRESENT;
                    w_en_nxt  = 1'b1;
                    load_head = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CLEAR: begin
                w_en_nxt    = 1'b0;
                clr_cnt_nxt = clr_cnt;
                if (clr_req) begin
                    clr_cnt_nxt = '0;
                end else if (pixel_clken) begin
                    if (clr_cnt == CLR_LAST) begin
                        clr_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        clr_cnt_nxt = clr_cnt + CLR_ONE;
                    end
                end
            end
        endcase
        // A request not consumed by entering CLEAR this cycle stays pending
        clr_pend_nxt = clr_eff & (state_nxt != CLEAR);
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_count      <= '0;
            rr_last_b       <= 1'b1;
            clr_pend        <= 1'b0;
            clr_cnt         <= '0;
            disp_w_en       <= 1'b0;
            disp_din        <= 8'h00;
            disp_clr_screen <= 1'b0;
        end else begin
            state           <= state_nxt;
            clr_pend        <= clr_pend_nxt;
            clr_cnt         <= clr_cnt_nxt;
            disp_w_en       <= w_en_nxt;
            disp_clr_screen <= (state_nxt == CLEAR);
            if (load_head) begin
                disp_din <= {1'b0, head};
            end
            if (push) begin
                wr_ptr    <= wr_ptr + PTR_ONE;
                rr_last_b <= push_b;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage carries data only and is left out of reset
    always_ff @(posedge sys_clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_display_char_scheduler.sv
// Directed bench for display_char_scheduler: a vector table for the basic handshake plus
// hand-written sequences for arbitration, full FIFO, clear timing and asynchronous reset.
module tb_display_char_scheduler;
    localparam int DEPTH  = 16;
    localparam int TB_CLR = 24;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       pixel_clken, cpu_clken;
    logic       a_valid, b_valid, clr_req, disp_ready;
    logic [6:0] a_data, b_data;
    logic       a_ready, b_ready, disp_w_en, disp_address, disp_clr_screen, busy;
    logic [7:0] disp_din;
    logic [4:0] fifo_count;

    int passed = 0;
    int total  = 0;

    display_char_scheduler #(.DEPTH(DEPTH), .CLR_TICKS(TB_CLR)) dut (
        .sys_clock(sys_clock), .reset(reset), .pixel_clken(pixel_clken), .cpu_clken(cpu_clken),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .clr_req(clr_req), .disp_ready(disp_ready), .disp_w_en(disp_w_en),
        .disp_address(disp_address), .disp_din(disp_din), .disp_clr_screen(disp_clr_screen),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic       a_v;  logic [6:0] a_d;  logic b_v;  logic [6:0] b_d;
        logic       clr;  logic rdy;  logic pix;  logic cpu;
        logic       e_ar; logic e_br; logic e_we; logic [7:0] e_din;
        logic       e_cs; logic [4:0] e_cnt; logic e_busy;
    } vec_t;

    vec_t vt[10];

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_data = 7'h00; b_valid = 1'b0; b_data = 7'h00;
        clr_req = 1'b0; disp_ready = 1'b0; pixel_clken = 1'b1; cpu_clken = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_w_en(input string name);
        int n = 0;
        while (!disp_w_en && n < 20) begin
            tick();
            n++;
        end
        check({name, "_wait_w_en"}, disp_w_en, 1);
    endtask

    task automatic push_a(input logic [6:0] d);
        a_valid = 1'b1; a_data = d;
        tick();
        a_valid = 1'b0;
    endtask

    // Runs CLEAR to completion, counting pixel ticks seen while clear is driven
    task automatic run_clear(input int pulse_at, input bit pix_alt, output int ticks, output int viol);
        int  n = 0;
        bit  pulsed = 1'b0;
        ticks = 0;
        viol  = 0;
        while (disp_clr_screen && n < 500) begin
            pixel_clken = pix_alt ? n[0] : 1'b1;
            clr_req     = (pulse_at >= 0) && (ticks == pulse_at) && !pulsed;
            if (clr_req) begin
                pulsed = 1'b1;
                ticks  = 0;
            end else if (pixel_clken) begin
                ticks++;
            end
            if (disp_w_en) viol++;
            tick();
            n++;
        end
        clr_req     = 1'b0;
        pixel_clken = 1'b1;
        check("clear_terminates", (n < 500), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got [4];
        logic [7:0] exp_alt [4];
        int k, ticks, viol, bad;

        //        a_v   a_d     b_v   b_d     clr   rdy   pix   cpu    ar    br    we    din     cs    cnt    busy
        vt[0] = '{1'b1, 7'h41, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0};
        vt[1] = '{1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, 5'd1, 1'b0};
        vt[2] = '{1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, 5'd1, 1'b0};
        vt[3] = '{1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, 5'd1, 1'b0};
        vt[4] = '{1'b0, 7'h00, 1'b1, 7'h42, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 5'd1, 1'b0};
        vt[5] = '{1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h42, 1'b0, 5'd1, 1'b0};
        vt[6] = '{1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h42, 1'b0, 5'd0, 1'b0};
        vt[7] = '{1'b0, 7'h00, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h42, 1'b0, 5'd0, 1'b0};
        vt[8] = '{1'b0, 7'h00, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h42, 1'b1, 5'd0, 1'b1};
        vt[9] = '{1'b1, 7'h43, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h42, 1'b1, 5'd1, 1'b1};
        exp_alt[0] = 8'h31; exp_alt[1] = 8'h32; exp_alt[2] = 8'h31; exp_alt[3] = 8'h32;

        // Reset values
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("reset_outputs", {disp_w_en, disp_din, disp_clr_screen, fifo_count, busy, disp_address}, 0);
        reset = 1'b0;

        // Table: single push, gated acceptance, push during pop, settle, clear from idle
        for (int i = 0; i < 10; i++) begin
            a_valid = vt[i].a_v; a_data = vt[i].a_d; b_valid = vt[i].b_v; b_data = vt[i].b_d;
            clr_req = vt[i].clr; disp_ready = vt[i].rdy; pixel_clken = vt[i].pix; cpu_clken = vt[i].cpu;
            #1;
            check($sformatf("vec%0d_ready", i), {a_ready, b_ready}, {vt[i].e_ar, vt[i].e_br});
            tick();
            check($sformatf("vec%0d_out", i), {disp_w_en, disp_din, disp_clr_screen, fifo_count, busy},
                  {vt[i].e_we, vt[i].e_din, vt[i].e_cs, vt[i].e_cnt, vt[i].e_busy});
        end
        idle_inputs();
        run_clear(-1, 1'b0, ticks, viol);
        check("idle_clear_ticks", ticks, TB_CLR - 1);
        check("idle_clear_no_wen", viol, 0);
        tick();
        check("after_clear_present", {disp_w_en, disp_din}, {1'b1, 8'h43});

        // Round-robin alternation and readout order
        do_reset();
        a_valid = 1'b1; a_data = 7'h31; b_valid = 1'b1; b_data = 7'h32;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("alt%0d_ready", i), {a_ready, b_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("alt_count", fifo_count, 4);
        disp_ready = 1'b1;
        k = 0;
        for (int n = 0; n < 40 && k < 4; n++) begin
            if (disp_w_en) begin
                got[k] = disp_din;
                k++;
            end
            tick();
        end
        disp_ready = 1'b0;
        check("alt_drained", k, 4);
        for (int i = 0; i < 4; i++) check($sformatf("alt_order%0d", i), got[i], exp_alt[i]);
        check("alt_empty", fifo_count, 0);

        // Full FIFO
        do_reset();
        a_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            a_data = 7'(i + 'h50);
            tick();
        end
        b_valid = 1'b1; b_data = 7'h7f;
        #1;
        check("full_count_busy", {fifo_count, busy}, {5'd16, 1'b1});
        check("full_readys", {a_ready, b_ready}, 2'b00);
        check("full_head", {disp_w_en, disp_din}, {1'b1, 8'h50});
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        check("full_pop_count", {fifo_count, busy}, {5'd15, 1'b0});
        #1;
        check("full_one_slot_readys", {a_ready, b_ready}, 2'b01);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("full_refill_count", fifo_count, 16);
        check("full_next_head", {disp_w_en, disp_din}, {1'b1, 8'h51});

        // Clear while presenting without acceptance
        do_reset();
        push_a(7'h48);
        wait_w_en("clr_present");
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_present_enter", {disp_w_en, disp_clr_screen, busy, fifo_count}, {3'b011, 5'd1});
        run_clear(-1, 1'b1, ticks, viol);
        check("clr_present_ticks", ticks, TB_CLR);
        check("clr_present_no_wen", viol, 0);
        tick();
        check("clr_represent", {disp_w_en, disp_din}, {1'b1, 8'h48});

        // Clear coinciding with acceptance, plus restart mid-clear
        do_reset();
        push_a(7'h49);
        wait_w_en("clr_accept");
        disp_ready = 1'b1; clr_req = 1'b1;
        tick();
        disp_ready = 1'b0; clr_req = 1'b0;
        check("clr_accept_enter", {fifo_count, disp_w_en, disp_clr_screen}, {5'd0, 2'b01});
        run_clear(10, 1'b0, ticks, viol);
        check("clr_restart_ticks", ticks, TB_CLR);
        check("clr_accept_no_wen", viol, 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (disp_w_en || fifo_count != 0) bad++;
        end
        check("clr_accept_single_pop", bad, 0);

        // Asynchronous reset mid-PRESENT
        do_reset();
        push_a(7'h4a);
        wait_w_en("rst_present");
        #2 reset = 1'b1;
        #1;
        check("rst_present_async", {disp_w_en, disp_din, disp_clr_screen, fifo_count, busy}, 0);
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("rst_present_lost", {disp_w_en, fifo_count}, 0);

        // Asynchronous reset mid-CLEAR
        push_a(7'h4b);
        push_a(7'h4c);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rst_clear_before", {disp_clr_screen, fifo_count}, {1'b1, 5'd2});
        #2 reset = 1'b1;
        #1;
        check("rst_clear_async", {disp_w_en, disp_din, disp_clr_screen, fifo_count, busy}, 0);
        tick();
        reset = 1'b0;
        tick(); tick(); tick(); tick();
        check("rst_clear_lost", {disp_w_en, disp_clr_screen, fifo_count}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
